// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// functs and ALU control codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. master = controller, slave = datapath.
interface multicycle_controller_if #(parameter int STATE_W = 4);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               memready;
  logic               iord;
  logic               memwrite;
  logic               irwrite;
  logic               pcen;
  logic [1:0]         pcsrc;
  logic               alusrca;
  logic [1:0]         alusrcb;
  logic [2:0]         alucontrol;
  logic               regdst;
  logic               memtoreg;
  logic               regwrite;
  logic               illegal_op;
  logic [STATE_W-1:0] state_o;

  modport master (
    input  op, funct, zero, memready,
    output iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
           alucontrol, regdst, memtoreg, regwrite, illegal_op, state_o
  );

  modport slave (
    output op, funct, zero, memready,
    input  iord, memwrite, irwrite, pcen, pcsrc, alusrca, alusrcb,
           alucontrol, regdst, memtoreg, regwrite, illegal_op, state_o
  );
endinterface

// File: rtl/mc_alu_decode.sv
// Combinational aluop/funct -> 3-bit ALU control.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing the multicycle MIPS datapath.
// Define MC_BNE_EN to add bne support through the BRANCH state.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_controller_if.master  bus
);

  state_e     state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch, br_take;
  logic       irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

`ifdef MC_BNE_EN
  logic bne_q, bne_d;

  always_comb begin
    bne_d = bne_q;
    if (state_q == S_FETCH)       bne_d = 1'b0;
    else if (state_q == S_DECODE) bne_d = (bus.op == OP_BNE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bne_q <= 1'b0;
    else       bne_q <= bne_d;
  end

  assign br_take = bne_q ? ~bus.zero : bus.zero;
`else
  assign br_take = bus.zero;
`endif

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = bus.memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = bus.memready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = bus.memready ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.iord      = 1'b0;
    memwrite_raw  = 1'b0;
    irwrite_raw   = 1'b0;
    pcwrite       = 1'b0;
    branch        = 1'b0;
    bus.pcsrc     = 2'b00;
    bus.alusrca   = 1'b0;
    bus.alusrcb   = 2'b00;
    aluop         = ALUOP_ADD;
    bus.regdst    = 1'b0;
    bus.memtoreg  = 1'b0;
    regwrite_raw  = 1'b0;
    illegal_raw   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.alusrcb = 2'b01;
        irwrite_raw = bus.memready;
        pcwrite     = bus.memready;
      end
      S_DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_raw = 1'b0;
`ifdef MC_BNE_EN
          OP_BNE:  illegal_raw = 1'b0;
`endif
          default: illegal_raw = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD: bus.iord = 1'b1;
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        memwrite_raw = 1'b1;
      end
      S_EXECUTE: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        bus.regdst   = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are masked by reset so an aborted instruction can't commit.
  assign bus.memwrite   = memwrite_raw & ~reset;
  assign bus.irwrite    = irwrite_raw  & ~reset;
  assign bus.regwrite   = regwrite_raw & ~reset;
  assign bus.illegal_op = illegal_raw  & ~reset;
  assign bus.pcen       = (pcwrite | (branch & br_take)) & ~reset;
  assign bus.state_o    = STATE_W'(state_q);

  mc_alu_decode u_alu_decode (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore FSM that sequences the shared multicycle MIPS datapath: one memory, one ALU, instruction register, PC. Decodes the latched opcode and funct. Drives per-state mux selects, write enables and ALU control. Stretches memory states on a ready handshake. Sits beside the datapath in the multicycle top level, in place of the single-cycle decoders.

Parameters:
STATE_W, 4, width of state register and debug state output.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces FETCH
op  in  6  instr[31:26] from instruction register
funct  in  6  instr[5:0] from instruction register
zero  in  1  ALU zero flag
memready  in  1  memory completes the current access this cycle
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
memwrite  out  1  memory write strobe
irwrite  out  1  instruction register load
pcen  out  1  PC load = pcwrite | (branch & zero)
pcsrc  out  2  next-PC select: 00 ALU result, 01 ALUOut, 10 jump target
alusrca  out  1  ALU A select: 0 = PC, 1 = register A
alusrcb  out  2  ALU B select: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
regdst  out  1  write register select: 0 = rt, 1 = rd
memtoreg  out  1  write-back data select: 0 = ALUOut, 1 = memory data
regwrite  out  1  register file write enable
illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
state_o  out  STATE_W  current state, debug

Behaviour:
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 are unreachable and return to FETCH.
- Reset: state becomes FETCH asynchronously. While reset is high, memwrite, irwrite, pcen, regwrite and illegal_op are forced 0. All other outputs take their FETCH values.
- Outputs are decoded from state only, except pcen (also uses zero). Any output not listed for a state is 0. alucontrol comes from the internal aluop.
- FETCH: alusrcb=01, aluop=00; irwrite=pcen=memready. Next state is DECODE if memready, else stay in FETCH.
- DECODE: alusrcb=11, aluop=00 (precomputes branch target). Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEX
  - 000010 (j) -> JUMP
  - any other op -> FETCH, with illegal_op=1 for this cycle.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next is MEMWB if memready, else stay.
- MEMWB: memtoreg=1, regwrite=1. Next is FETCH.
- MEMWR: iord=1, memwrite=1, held every cycle until memready. Next is FETCH if memready, else stay.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10. Next is ALUWB.
- ALUWB: regdst=1, regwrite=1. Next is FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1, so pcen=zero. Next is FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next is ADDIWB.
- ADDIWB: regwrite=1. Next is FETCH.
- JUMP: pcsrc=10, pcen=1. Next is FETCH.
- ALU decode: aluop 00 -> add; 01 -> sub; 10 -> by funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - any other funct -> 010 (add). regwrite in ALUWB is unaffected.
- Latency with memready held high (cycles): R-type 4, lw 5, sw 4, beq 3, addi 4, j 3. Each low-memready cycle in FETCH, MEMRD or MEMWR adds one cycle.
- op and funct are sampled only in the states above; they may change at any other time.
- Reset asserted mid-instruction aborts it: no register or memory write completes after reset rises.

Optional Feature:
MC_BNE_EN
- Defined: op 000101 (bne) goes DECODE -> BRANCH. In BRANCH, pcen = ~zero for bne and zero for beq. Bne is tracked by a flag latched in DECODE and cleared in FETCH.
- Undefined: op 000101 is illegal (illegal_op pulse, return to FETCH).

Decomposition:
- Shared package mc_pkg holds:
  - state encodings
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE
  - funct constants
  - aluop and alucontrol constants
- One sub-module, mc_alu_decode: combinational aluop/funct -> alucontrol, instantiated once.

Test Plan:
- Reset high for 2 cycles, then released with memready=1 -> state_o=0, irwrite=1 and pcen=1 in the first post-reset cycle; irwrite/pcen=0 while reset high.
- lw (op 100011), memready=1 -> states 0,1,2,3,4 over 5 cycles; regwrite=1 and memtoreg=1 only in MEMWB.
- sw with memready low for 3 cycles in MEMWR -> memwrite high for 4 consecutive cycles, then FETCH; regwrite never asserted.
- R-type funct 101010 -> alucontrol=111 in EXECUTE, regdst=1/regwrite=1 in ALUWB, 4 cycles total. beq with zero=1 gives pcen=1 in BRANCH; with zero=0, pcen=0.
- op 111111 -> DECODE pulses illegal_op=1 for exactly 1 cycle, next state FETCH. Reset asserted during MEMRD -> state 0 immediately, no regwrite.
- With MC_BNE_EN defined: op 000101 and zero=0 -> pcen=1 in BRANCH. Without it: illegal_op pulse.
